// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//
//   start   core -> unit  request a new M-extension operation (sampled in IDLE)
//   funct3  core -> unit  RV32M selector
//   op_a    core -> unit  rs1 value
//   op_b    core -> unit  rs2 value
//   kill    core -> unit  abort the in-flight operation (pipeline flush)
//   busy    unit -> core  operation in progress; core holds PC / stalls writeback
//   done    unit -> core  one-cycle completion pulse, result valid in that cycle
//   result  unit -> core  last completed result, held until the next done
interface muldiv_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  // Core side: issues requests, observes status and result.
  modport master (
    output start, funct3, op_a, op_b, kill,
    input  busy, done, result
  );

  // Unit side.
  modport slave (
    input  start, funct3, op_a, op_b, kill,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// One operation per accepted start. Multiplies use a 2*XLEN shift-add product
// register, divides use a restoring remainder/quotient pair; both take XLEN
// iterations on unsigned magnitudes, with the sign applied once at the end.
// Divide-by-zero and signed overflow bypass the iteration and complete in one
// cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_unit_if.slave: start/funct3/op_a/op_b/kill in,
//          busy/done/result out (all outputs registered or decoded from state)
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,  state_d;
  logic [2:0]        op_q,     op_d;
  logic [XLEN-1:0]   a_mag_q,  a_mag_d;    // multiplicand / (unused for divide)
  logic [XLEN-1:0]   b_mag_q,  b_mag_d;    // divisor magnitude
  logic              neg_q,    neg_d;      // operand signs differ (product / quotient)
  logic              a_neg_q,  a_neg_d;    // dividend negative (remainder sign)
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [2*XLEN-1:0] prod_q,   prod_d;     // {accumulated high, remaining multiplier}
  logic [XLEN-1:0]   rem_q,    rem_d;
  logic [XLEN-1:0]   quo_q,    quo_d;      // dividend bits shift out, quotient bits in
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q,   done_d;

  // ---------------------------------------------------------------------------
  // Operand decode at capture time
  // ---------------------------------------------------------------------------
  logic            a_signed, b_signed;
  logic            a_sign_in, b_sign_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            is_div_in, b_zero_in, ovf_in, fast_hit;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    // MUL is treated as unsigned: its low word does not depend on signedness.
    a_signed  = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
    b_signed  = (bus.funct3 == F_MULH) ||
                (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
    a_sign_in = a_signed && bus.op_a[XLEN-1];
    b_sign_in = b_signed && bus.op_b[XLEN-1];
    // The most negative value negates to itself, which is also its correct
    // unsigned magnitude, so no extra width is needed.
    a_mag_in  = a_sign_in ? -bus.op_a : bus.op_a;
    b_mag_in  = b_sign_in ? -bus.op_b : bus.op_b;

    is_div_in = bus.funct3[2];
    b_zero_in = (bus.op_b == '0);
    ovf_in    = !bus.funct3[0] &&
                (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                (bus.op_b == '1);
    fast_hit  = is_div_in && (b_zero_in || ovf_in);

    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (b_zero_in) begin
      fast_result = bus.funct3[1] ? bus.op_a : '1;
    end else begin
      fast_result = bus.funct3[1] ? '0 : bus.op_a;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration of each datapath, plus final selection and sign fix-up
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   rem_step, quo_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   final_result;

  always_comb begin
    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole register right, carry included.
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                (prod_q[0] ? {1'b0, a_mag_q} : '0);
    prod_step = {mul_sum, prod_q[XLEN-1:1]};

    // Restoring divide: a set top bit of the trial difference means it went
    // negative, so the shifted remainder is kept and the quotient bit is 0.
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    if (!div_diff[XLEN]) begin
      rem_step = div_diff[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_step = div_shift[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end

    // The product is negated across its full width so the high word is right.
    prod_fix = neg_q   ? -prod_step : prod_step;
    quo_fix  = neg_q   ? -quo_step  : quo_step;
    rem_fix  = a_neg_q ? -rem_step  : rem_step;

    case (op_q)
      F_MUL:                      final_result = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  final_result = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              final_result = quo_fix;
      default:                    final_result = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path through
    // this block leaves one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // kill has no effect here; a simultaneous start is honoured.
        if (bus.start) begin
          if (fast_hit) begin
            state_d  = S_DONE;
            result_d = fast_result;
            done_d   = 1'b1;
          end else begin
            state_d  = S_RUN;
            op_d     = bus.funct3;
            a_mag_d  = a_mag_in;
            b_mag_d  = b_mag_in;
            neg_d    = a_sign_in ^ b_sign_in;
            a_neg_d  = a_sign_in;
            cnt_d    = '0;
            prod_d   = {{XLEN{1'b0}}, b_mag_in};
            rem_d    = '0;
            quo_d    = a_mag_in;
          end
        end
      end

      S_RUN: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          // Both datapaths step every cycle; op_q picks which one is reported.
          prod_d = prod_step;
          rem_d  = rem_step;
          quo_d  = quo_step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d  = S_DONE;
            result_d = final_result;
            done_d   = 1'b1;
          end
        end
      end

      // Leaves after one cycle whether or not kill is asserted.
      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values that
      // existed before this edge, independent of statement order.
      state_q  <= state_d;
      op_q     <= op_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed-vector bench for muldiv_unit.
// The driver pushes each expected result and the expected done cycle into a
// scoreboard queue; an independent monitor pops and compares on every done.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t  exp_q[$];
  string name_q[$];
  logic  prev_done = 1'b0;
  exp_t  cur;
  string cur_name;
  logic [XLEN-1:0] held;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // cyc holds n during the period that follows rising edge n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      check("done_not_back_to_back", {{(XLEN-1){1'b0}}, prev_done}, '0);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: result=0x%08h at cycle %0d, required no done",
                 bus.result, cyc);
      end else begin
        cur      = exp_q.pop_front();
        cur_name = name_q.pop_front();
        check(cur_name, bus.result, cur.res);
        check({cur_name, "_cycle"}, XLEN'(cyc), XLEN'(cur.cyc));
      end
    end
    prev_done <= bus.done;
  end

  // Called at a negedge. Presents one request for one cycle, optionally
  // recording the expected result due lat cycles after acceptance.
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input bit expect_done,
                       input logic [XLEN-1:0] res, input int lat,
                       input string nm, input logic with_kill);
    exp_t e;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.kill   = with_kill;
    if (expect_done) begin
      e.res = res;
      e.cyc = cyc + lat;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(negedge clk);
    // Scramble the inputs so a unit that re-samples them gives a wrong answer.
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = ~f;
    bus.op_a   = 32'hA5A5_5A5A;
    bus.op_b   = 32'h5A5A_A5A5;
  endtask

  // Returns at the first negedge with busy low (the earliest next-start slot).
  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      compared++;
      mismatched++;
      $display("FAIL wait_idle_timeout: busy=%b after %0d cycles, required 0",
               bus.busy, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, compared=%0d", compared);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.kill   = 1'b0;
    #12;
    check("reset_busy",   {{(XLEN-1){1'b0}}, bus.busy}, '0);
    check("reset_done",   {{(XLEN-1){1'b0}}, bus.done}, '0);
    check("reset_result", bus.result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiplies: 7 * -3 low word, unsigned high word, signed/mixed highs.
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 33, "mul_7_x_fffffffd", 1'b0);
    wait_idle();
    issue(3'b011, 32'd7, 32'hFFFF_FFFD, 1, 32'h0000_0006, 33, "mulhu_7_x_fffffffd", 1'b0);
    wait_idle();
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 33, "mulh_min_x_min", 1'b0);
    wait_idle();
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 1, 32'hFFFF_FFFF, 33, "mulhsu_m1_x_2", 1'b0);
    wait_idle();

    // Divides: signed with mixed signs, unsigned quotient/remainder.
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 33, "div_m7_by_2", 1'b0);
    wait_idle();
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 33, "rem_m7_by_2", 1'b0);
    wait_idle();
    issue(3'b101, 32'd100, 32'd7, 1, 32'd14, 33, "divu_100_by_7", 1'b0);
    wait_idle();
    issue(3'b111, 32'd100, 32'd7, 1, 32'd2, 33, "remu_100_by_7", 1'b0);
    wait_idle();

    // Fast path: divide by zero and signed overflow complete in one cycle.
    issue(3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1, "divu_5_by_0", 1'b0);
    wait_idle();
    issue(3'b111, 32'd5, 32'd0, 1, 32'd5, 1, "remu_5_by_0", 1'b0);
    wait_idle();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, "div_overflow", 1'b0);
    wait_idle();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1, "rem_overflow", 1'b0);
    wait_idle();

    // start with kill in IDLE: start wins.
    issue(3'b111, 32'd100, 32'd7, 1, 32'd2, 33, "remu_with_kill_in_idle", 1'b1);
    wait_idle();

    // Abort a DIV ten cycles in; the result register must keep its old value.
    issue(3'b100, 32'd1000, 32'd3, 0, '0, 0, "div_killed", 1'b0);
    repeat (9) @(negedge clk);
    check("busy_before_kill", {{(XLEN-1){1'b0}}, bus.busy}, {{(XLEN-1){1'b0}}, 1'b1});
    held     = bus.result;
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy_low", {{(XLEN-1){1'b0}}, bus.busy}, '0);
    check("kill_result_held", bus.result, held);

    // Re-arm immediately, with a stray start pulse during RUN that must be ignored.
    issue(3'b000, 32'd3, 32'd4, 1, 32'd12, 33, "mul_3_x_4_after_kill", 1'b0);
    repeat (5) @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.op_a   = 32'd1;
    bus.op_b   = 32'd0;
    @(negedge clk);
    bus.start  = 1'b0;
    check("busy_after_stray_start", {{(XLEN-1){1'b0}}, bus.busy}, {{(XLEN-1){1'b0}}, 1'b1});
    wait_idle();

    // Asynchronous reset mid-RUN clears the outputs without waiting for a clock.
    issue(3'b000, 32'd9, 32'd9, 0, '0, 0, "mul_reset", 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_busy",   {{(XLEN-1){1'b0}}, bus.busy}, '0);
    check("midrun_reset_done",   {{(XLEN-1){1'b0}}, bus.done}, '0);
    check("midrun_reset_result", bus.result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'b000, 32'd2, 32'd2, 1, 32'd4, 33, "mul_2_x_2_after_reset", 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", XLEN'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit with its own sequencing FSM, placed beside the main ALU in the execute stage. It accepts one M-extension operation per start pulse, runs a shift-add multiply or a restoring divide over XLEN cycles, and signals completion with a one-cycle done pulse. While busy, the core holds the PC and stalls register writeback.

## Interface

- XLEN, 32: operand and result width. Must be a power of two, at least 8.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- funct3  input  3  RV32M selector: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value; captured on the cycle start is accepted.
- op_b  input  XLEN  rs2 value; captured on the cycle start is accepted.
- kill  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  XLEN  result of the last completed operation; holds until the next done.

## Operation

- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: presenting the result for one cycle.
- IDLE → RUN: start=1 and no fast-path condition. Capture funct3, |op_a|, |op_b|, and the result sign. Clear the iteration counter, which is $clog2(XLEN)+1 bits wide.
- IDLE → DONE (fast path): start=1 with a divide/remainder opcode (funct3[2]=1) and either of these conditions:
  - op_b = 0: DIV/DIVU result = all ones; REM/REMU result = op_a.
  - Signed overflow, i.e. DIV/REM with op_a = 1 followed by XLEN-1 zeros and op_b = all ones: DIV result = op_a; REM result = 0.
- Operand signedness:
  - MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - DIV/REM: both operands signed.
  - MULHU/DIVU/REMU: both operands unsigned.
  - MUL: the low word is the same either way; treat both as unsigned.
- Signed operands are converted to magnitude on capture. The datapath is purely unsigned.
- RUN, multiply: 2·XLEN-bit product register, one shift-add step per cycle.
- RUN, divide: XLEN-bit remainder register plus quotient register, one restoring subtract/shift step per cycle.
- RUN → DONE: after exactly XLEN iterations (counter reaches XLEN-1 on the last step).
- Result selection in DONE:
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Sign fix-up in DONE, applied by two's-complement negation:
  - Product negated if the operand signs differ.
  - Quotient negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- DONE → IDLE unconditionally on the next cycle. result is registered and holds its value afterward.
- kill=1 in RUN or DONE: go to IDLE on the next edge. No done pulse; result is not updated. kill in IDLE has no effect. If kill and start are both high in IDLE, start is honoured.
- start while busy=1: ignored. Inputs are not re-captured.
- Reset (asynchronous, at any time, including mid-operation): state=IDLE, busy=0, done=0, result=0, counter and internal registers cleared.

## Timing

- Start accepted at edge k (IDLE, start=1).
- Normal path:
  - busy=1 from k+1 onward.
  - RUN occupies cycles k+1 … k+XLEN.
  - DONE is cycle k+XLEN+1, with done=1 and result valid.
  - busy=0 from k+XLEN+2.
  - Latency is XLEN+1 cycles (33 at XLEN=32).
- Fast path: DONE in cycle k+1 (done=1, result valid); busy=0 from k+2. Latency is 1 cycle.
- Back-to-back throughput: the earliest next start is accepted in the first cycle after DONE (normal path: k+XLEN+2).
- kill asserted in cycle j (RUN/DONE): busy=0 from j+1; a new start is accepted in j+1.
- done is never high for two consecutive cycles.
- Output derivation:
  - busy is a decode of registered state.
  - done is registered.
  - result is registered.
  - No combinational path from inputs to outputs.

## Test plan

- Multiply: MUL op_a=7, op_b=0xFFFFFFFD.
  - done at exactly k+33, result 0xFFFFFFEB.
  - MULHU with the same operands → 0x00000006.
- High multiply: MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- Signed divide: DIV -7/2 → 0xFFFFFFFD. REM -7%2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100%7 → 2. Each has latency 33.
- Corner cases via fast path:
  - DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, with done at k+1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, with done at k+1.
- Abort and re-arm:
  - Assert kill 10 cycles into a DIV: busy=0 next cycle, no done, result unchanged.
  - An immediately following MUL 3×4 → 12 at +33.
  - start pulsed during RUN is ignored.
- Reset mid-operation: drop rst_n asynchronously during RUN. busy, done, and result go to 0 immediately. After release, a MUL 2×2 completes with result 4.
